// File: rtl/lcm_pkg.sv
// Shared definitions for the LCM calculator: FSM state encoding and default operand width.
package lcm_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StCapt = 3'd3,
    StDiv  = 3'd4,
    StMul  = 3'd5,
    StDone = 3'd6
  } lcm_state_e;

endpackage

// File: rtl/lcm_calculator_if.sv
// Operand/result handshake plus the GCD-stage side channel of the LCM calculator.
interface lcm_calculator_if #(
  parameter int unsigned WIDTH = lcm_pkg::DefaultWidth
);

  logic               start;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               gcd_start;
  logic [WIDTH-1:0]   gcd_a;
  logic [WIDTH-1:0]   gcd_b;
  logic               gcd_done;
  logic [WIDTH-1:0]   gcd_in;
  logic               busy;
  logic               done;
  logic               err;
  logic [2*WIDTH-1:0] lcm_out;

  // The calculator itself.
  modport slave (
    input  start, in1, in2, gcd_done, gcd_in,
    output gcd_start, gcd_a, gcd_b, busy, done, err, lcm_out
  );

  // Operand source, result sink and GCD peer seen as one agent.
  modport master (
    output start, in1, in2, gcd_done, gcd_in,
    input  gcd_start, gcd_a, gcd_b, busy, done, err, lcm_out
  );

endinterface

// File: rtl/lcm_calculator_seq_shift_add_mul.sv
// Sequential LSB-first shift-add multiplier: while go is held it takes WIDTH cycles and flags
// ready in the last one, with product carrying the final sum in that same cycle.
module seq_shift_add_mul
  import lcm_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   xs_q, xs_d, xs_cur;
  logic [2*WIDTH-1:0] ys_q, ys_d, ys_cur;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_cur;
  logic               first;

  // The first step works straight from x/y so the whole multiply fits in WIDTH cycles.
  always_comb begin
    first   = (cnt_q == '0);
    xs_cur  = first ? x : xs_q;
    ys_cur  = first ? {{WIDTH{1'b0}}, y} : ys_q;
    acc_cur = first ? '0 : acc_q;
    product = acc_cur + (xs_cur[0] ? ys_cur : '0);
    ready   = go && (cnt_q == CntW'(WIDTH - 1));
    xs_d    = xs_cur >> 1;
    ys_d    = ys_cur << 1;
    acc_d   = product;
    cnt_d   = (go && !ready) ? cnt_q + CntW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      xs_q  <= '0;
      ys_q  <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (go) begin
        xs_q  <= xs_d;
        ys_q  <= ys_d;
        acc_q <= acc_d;
      end
    end
  end

endmodule

// File: rtl/lcm_calculator.sv
// LCM = (a / gcd) * b, with the GCD supplied by a peer stage. Optional GCD-wait watchdog
// enabled by defining LCM_WATCHDOG_EN.
module lcm_calculator
  import lcm_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned TIMEOUT = 64
) (
  input logic             clk,
  input logic             reset,
  lcm_calculator_if.slave bus
);

  lcm_state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, g_q, g_d, q_q, q_d, r_q, r_d;
  logic [2*WIDTH-1:0] lcm_q, lcm_d;
  logic               done_q;
  logic               mul_go, mul_ready;
  logic [2*WIDTH-1:0] mul_product;

`ifdef LCM_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT) + 1;
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    q_d     = q_q;
    r_d     = r_q;
    lcm_d   = lcm_q;
`ifdef LCM_WATCHDOG_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.in1 == '0 || bus.in2 == '0) begin
            lcm_d   = '0;
            state_d = StDone;
          end else begin
            a_d     = bus.in1;
            b_d     = bus.in2;
            state_d = StReq;
          end
        end
      end
      StReq: begin
`ifdef LCM_WATCHDOG_EN
        wd_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (bus.gcd_done) begin
          state_d = StCapt;
`ifdef LCM_WATCHDOG_EN
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          lcm_d   = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wd_d = wd_q + WdW'(1);
`endif
        end
      end
      StCapt: begin
        g_d = bus.gcd_in;
        q_d = '0;
        r_d = a_q;
        if (bus.gcd_in == '0) begin
          lcm_d   = '0;
          state_d = StDone;
        end else begin
          state_d = StDiv;
        end
      end
      StDiv: begin
        r_d = r_q - g_q;
        q_d = q_q + WIDTH'(1);
        // <= rather than == keeps a bogus non-divisor GCD from looping forever.
        if (r_q <= g_q) state_d = StMul;
      end
      StMul: begin
        if (mul_ready) begin
          lcm_d   = mul_product;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      g_q    <= '0;
      q_q    <= '0;
      r_q    <= '0;
      lcm_q  <= '0;
      done_q <= 1'b0;
`ifdef LCM_WATCHDOG_EN
      wd_q   <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      g_q    <= g_d;
      q_q    <= q_d;
      r_q    <= r_d;
      lcm_q  <= lcm_d;
      done_q <= (state_d == StDone);
`ifdef LCM_WATCHDOG_EN
      wd_q   <= wd_d;
      err_q  <= err_d;
`endif
    end
  end

  assign mul_go = (state_q == StMul);

  seq_shift_add_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .go      (mul_go),
    .x       (q_q),
    .y       (b_q),
    .ready   (mul_ready),
    .product (mul_product)
  );

  assign bus.busy      = (state_q != StIdle);
  assign bus.gcd_start = (state_q == StReq);
  assign bus.gcd_a     = a_q;
  assign bus.gcd_b     = b_q;
  assign bus.done      = done_q;
  assign bus.lcm_out   = lcm_q;
`ifdef LCM_WATCHDOG_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_lcm_calculator.sv
// Directed bench for lcm_calculator; the bench itself plays the GCD stage with programmed results.
module tb_lcm_calculator;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lcm_calculator_if #(.WIDTH(4)) bus ();

  lcm_calculator #(
    .WIDTH   (4),
    .TIMEOUT (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and acts as the GCD stage: gcd_done pulses 'delay' cycles after
  // gcd_start (0 = never), gcd_in becomes valid the cycle after that pulse.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] g,
                        input int delay, input int repulse_at, input int budget,
                        output bit got_done, output int lat, output logic [7:0] lcm,
                        output logic e, output int starts, output logic [3:0] ga,
                        output logic [3:0] gb, output logic done_next);
    int pending;
    bit fire_prev;
    got_done  = 1'b0;
    lat       = 0;
    lcm       = '0;
    e         = 1'b0;
    starts    = 0;
    ga        = '0;
    gb        = '0;
    done_next = 1'b0;
    pending   = 0;
    fire_prev = 1'b0;
    bus.gcd_in = 4'h0;
    bus.start  = 1'b1;
    bus.in1    = a;
    bus.in2    = b;
    step();
    bus.start = 1'b0;
    bus.in1   = 4'hA;
    bus.in2   = 4'h5;
    for (int i = 1; i <= budget; i++) begin
      if (fire_prev) begin
        bus.gcd_done = 1'b0;
        bus.gcd_in   = g;
        fire_prev    = 1'b0;
      end
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          bus.gcd_done = 1'b1;
          fire_prev    = 1'b1;
        end
      end
      if (bus.gcd_start) begin
        starts++;
        ga = bus.gcd_a;
        gb = bus.gcd_b;
        if (delay > 0) pending = delay;
      end
      if (i == repulse_at) begin
        bus.start = 1'b1;
        bus.in1   = 4'd3;
        bus.in2   = 4'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        got_done = 1'b1;
        lat      = i;
        lcm      = bus.lcm_out;
        e        = bus.err;
        break;
      end
      step();
    end
    bus.start    = 1'b0;
    bus.gcd_done = 1'b0;
    if (got_done) begin
      step();
      done_next = bus.done;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b err=%b required 000", bus.busy, bus.done,
               bus.err);
    end
    checks++;
    if (bus.gcd_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_gcd_start got %b required 0", bus.gcd_start);
    end
    checks++;
    if (bus.gcd_a !== 4'd0 || bus.gcd_b !== 4'd0) begin
      errors++;
      $display("FAIL reset_gcd_ab got %0d,%0d required 0,0", bus.gcd_a, bus.gcd_b);
    end
    checks++;
    if (bus.lcm_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_lcm got %0d required 0", bus.lcm_out);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic;
    bit got; int lat; logic [7:0] lcm; logic e; int st; logic [3:0] ga, gb; logic dn;
    run_op(4'd12, 4'd8, 4'd4, 1, 0, 60, got, lat, lcm, e, st, ga, gb, dn);
    checks++;
    if (!got) begin errors++; $display("FAIL basic_done no done within budget"); end
    checks++;
    if (lcm !== 8'd24) begin errors++; $display("FAIL basic_lcm got %0d required 24", lcm); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL basic_err got %b required 0", e); end
    checks++;
    if (lat != 11) begin errors++; $display("FAIL basic_latency got %0d required 11", lat); end
    checks++;
    if (st != 1) begin errors++; $display("FAIL basic_gcd_start pulses got %0d required 1", st); end
    checks++;
    if (ga !== 4'd12 || gb !== 4'd8) begin
      errors++;
      $display("FAIL basic_gcd_ab got %0d,%0d required 12,8", ga, gb);
    end
    checks++;
    if (dn !== 1'b0) begin errors++; $display("FAIL basic_done_width done still %b", dn); end
  endtask

  task automatic test_equal;
    bit got; int lat; logic [7:0] lcm; logic e; int st; logic [3:0] ga, gb; logic dn;
    run_op(4'd15, 4'd15, 4'd15, 3, 0, 60, got, lat, lcm, e, st, ga, gb, dn);
    checks++;
    if (lcm !== 8'd15) begin errors++; $display("FAIL equal_lcm got %0d required 15", lcm); end
    checks++;
    if (lat != 11) begin errors++; $display("FAIL equal_latency got %0d required 11", lat); end
  endtask

  task automatic test_coprime;
    bit got; int lat; logic [7:0] lcm; logic e; int st; logic [3:0] ga, gb; logic dn;
    run_op(4'd13, 4'd7, 4'd1, 2, 0, 80, got, lat, lcm, e, st, ga, gb, dn);
    checks++;
    if (lcm !== 8'd91) begin errors++; $display("FAIL coprime_lcm got %0d required 91", lcm); end
    checks++;
    if (lat != 22) begin errors++; $display("FAIL coprime_latency got %0d required 22", lat); end
    run_op(4'd15, 4'd14, 4'd1, 1, 0, 80, got, lat, lcm, e, st, ga, gb, dn);
    checks++;
    if (lcm !== 8'd210) begin errors++; $display("FAIL max_lcm got %0d required 210", lcm); end
    checks++;
    if (lat != 23) begin errors++; $display("FAIL max_latency got %0d required 23", lat); end
  endtask

  task automatic test_zero_operand;
    bit got; int lat; logic [7:0] lcm; logic e; int st; logic [3:0] ga, gb; logic dn;
    run_op(4'd0, 4'd9, 4'd3, 1, 0, 10, got, lat, lcm, e, st, ga, gb, dn);
    checks++;
    if (!got || lat > 2) begin
      errors++;
      $display("FAIL zero_latency got_done=%b latency %0d required <=2", got, lat);
    end
    checks++;
    if (lcm !== 8'd0) begin errors++; $display("FAIL zero_lcm got %0d required 0", lcm); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL zero_err got %b required 0", e); end
    checks++;
    if (st != 0) begin errors++; $display("FAIL zero_gcd_start pulses got %0d required 0", st); end
    checks++;
    if (dn !== 1'b0) begin errors++; $display("FAIL zero_done_width done still %b", dn); end
    run_op(4'd9, 4'd0, 4'd3, 1, 0, 10, got, lat, lcm, e, st, ga, gb, dn);
    checks++;
    if (!got || lat != 1 || st != 0) begin
      errors++;
      $display("FAIL zero_b got_done=%b latency %0d pulses %0d required 1,1,0", got, lat, st);
    end
  endtask

  task automatic test_repulse_in_div;
    bit got; int lat; logic [7:0] lcm; logic e; int st; logic [3:0] ga, gb; logic dn;
    run_op(4'd13, 4'd7, 4'd1, 1, 6, 80, got, lat, lcm, e, st, ga, gb, dn);
    checks++;
    if (lcm !== 8'd91) begin errors++; $display("FAIL repulse_lcm got %0d required 91", lcm); end
    checks++;
    if (lat != 21) begin errors++; $display("FAIL repulse_latency got %0d required 21", lat); end
    checks++;
    if (st != 1) begin errors++; $display("FAIL repulse_gcd_start pulses got %0d required 1", st); end
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL repulse_idle busy=%b done=%b required 0,0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_in_wait;
    bit got; int lat; logic [7:0] lcm; logic e; int st; logic [3:0] ga, gb; logic dn;
    bit seen;
    run_op(4'd15, 4'd15, 4'd15, 1, 0, 60, got, lat, lcm, e, st, ga, gb, dn);
    checks++;
    if (lcm !== 8'd15) begin errors++; $display("FAIL pre_reset_lcm got %0d required 15", lcm); end
    bus.start = 1'b1;
    bus.in1   = 4'd12;
    bus.in2   = 4'd8;
    step();
    bus.start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags busy=%b done=%b required 0,0", bus.busy, bus.done);
    end
    checks++;
    if (bus.lcm_out !== 8'd0) begin
      errors++;
      $display("FAIL midreset_lcm got %0d required 0", bus.lcm_out);
    end
    checks++;
    if (bus.gcd_start !== 1'b0 || bus.gcd_a !== 4'd0) begin
      errors++;
      $display("FAIL midreset_gcd gcd_start=%b gcd_a=%0d required 0,0", bus.gcd_start, bus.gcd_a);
    end
    bus.gcd_in   = 4'd5;
    bus.gcd_done = 1'b1;
    step();
    bus.gcd_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy || bus.done || bus.gcd_start) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL spurious_gcd_done activity seen, required none"); end
  endtask

  task automatic test_wait_timeout;
    bit got; int lat; logic [7:0] lcm; logic e; int st; logic [3:0] ga, gb; logic dn;
    run_op(4'd12, 4'd8, 4'd4, 0, 0, 100, got, lat, lcm, e, st, ga, gb, dn);
    checks++;
    if (st != 1) begin errors++; $display("FAIL wait_gcd_start pulses got %0d required 1", st); end
`ifdef LCM_WATCHDOG_EN
    checks++;
    if (!got || lat != 66) begin
      errors++;
      $display("FAIL watchdog_latency got_done=%b latency %0d required 66", got, lat);
    end
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL watchdog_err got %b required 1", e); end
    checks++;
    if (lcm !== 8'd0) begin errors++; $display("FAIL watchdog_lcm got %0d required 0", lcm); end
`else
    checks++;
    if (got) begin errors++; $display("FAIL wait_blocks done seen at %0d, required none", lat); end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL wait_busy got %b required 1", bus.busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
`endif
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in1      = '0;
    bus.in2      = '0;
    bus.gcd_done = 1'b0;
    bus.gcd_in   = '0;
    test_reset();
    test_basic();
    test_equal();
    test_coprime();
    test_zero_operand();
    test_repulse_in_div();
    test_wait_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
